// File: rtl/dq_lane_burst.sv
// Burst sequencer for one DDR3 byte lane: serializes BL8 writes into 4-beat PHY words,
// gathers two 4-beat PHY captures into a 64-bit read burst, and controls DCI termination.
//
// state  | meaning
// IDLE   | lane tristated, termination off, ready for either command
// W_PRE  | write preamble, driver enabled, data zero
// W_D0   | write beats 0-3 on din
// W_D1   | write beats 4-7 on din
// W_POST | write post-amble; a new write here continues without preamble
// R_WAIT | counting down the programmed read latency, termination on
// R_CAP0 | capturing beats 0-3 from dout
// R_CAP1 | capturing beats 4-7 from dout, then publishing rd_data
module dq_lane_burst #(
  parameter int DQ_WIDTH = 8,
  parameter int LAT_BITS = 5
) (
  input  logic                    clk_div,
  input  logic                    rst_n,
  input  logic                    wr_start,
  input  logic [8*DQ_WIDTH-1:0]   wr_data,
  output logic                    wr_ready,
  input  logic                    rd_start,
  input  logic [LAT_BITS-1:0]     rd_lat,
  output logic                    rd_ready,
  output logic [8*DQ_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic [4*DQ_WIDTH-1:0]   din,
  output logic [4*DQ_WIDTH-1:0]   tin,
  input  logic [4*DQ_WIDTH-1:0]   dout,
  output logic                    dci_disable,
  output logic                    cmd_err
);

  localparam int BW = 8 * DQ_WIDTH;
  localparam int NW = 4 * DQ_WIDTH;

  typedef enum logic [2:0] {
    IDLE, W_PRE, W_D0, W_D1, W_POST, R_WAIT, R_CAP0, R_CAP1
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       wdat_q, wdat_d;
  logic [BW-1:0]       rd_data_q, rd_data_d;
  logic [NW-1:0]       cap_lo_q, cap_lo_d;
  logic [LAT_BITS-1:0] cnt_q, cnt_d;
  logic [NW-1:0]       din_q, din_d;
  logic [NW-1:0]       tin_q, tin_d;
  logic                dci_q, dci_d;
  logic                rd_valid_q, rd_valid_d;
  logic                cmd_err_q, cmd_err_d;
  logic                wr_ready_q, wr_ready_d;
  logic                rd_ready_q, rd_ready_d;
  logic                wr_ok, rd_ok;

  // Beat-major (k*DQ_WIDTH+i) to PHY bit-slice-major (4i+k) ordering, and back.
  function automatic logic [NW-1:0] to_phy(input logic [NW-1:0] beats);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < DQ_WIDTH; i++)
      for (int k = 0; k < 4; k++)
        r[4*i+k] = beats[k*DQ_WIDTH+i];
    return r;
  endfunction

  function automatic logic [NW-1:0] from_phy(input logic [NW-1:0] p);
    logic [NW-1:0] r;
    r = '0;
    for (int i = 0; i < DQ_WIDTH; i++)
      for (int k = 0; k < 4; k++)
        r[k*DQ_WIDTH+i] = p[4*i+k];
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    wdat_d     = wdat_q;
    rd_data_d  = rd_data_q;
    cap_lo_d   = cap_lo_q;
    cnt_d      = cnt_q;
    rd_valid_d = 1'b0;

    wr_ok     = wr_start && (state_q == IDLE || state_q == W_POST);
    rd_ok     = rd_start && (state_q == IDLE) && !wr_start;
    cmd_err_d = (wr_start && !wr_ok) || (rd_start && !rd_ok);

    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          wdat_d  = wr_data;
          state_d = W_PRE;
        end else if (rd_ok) begin
          cnt_d   = rd_lat;
          state_d = R_WAIT;
        end
      end
      W_PRE:  state_d = W_D0;
      W_D0:   state_d = W_D1;
      W_D1:   state_d = W_POST;
      W_POST: begin
        if (wr_ok) begin
          wdat_d  = wr_data;
          state_d = W_D0;
        end else begin
          state_d = IDLE;
        end
      end
      R_WAIT: begin
        if (cnt_q == '0) state_d = R_CAP0;
        else             cnt_d   = cnt_q - 1'b1;
      end
      R_CAP0: begin
        cap_lo_d = from_phy(dout);
        state_d  = R_CAP1;
      end
      R_CAP1: begin
        rd_data_d  = {from_phy(dout), cap_lo_q};
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    din_d = '0;
    tin_d = '1;
    case (state_d)
      W_PRE, W_POST: tin_d = '0;
      W_D0: begin
        tin_d = '0;
        din_d = to_phy(wdat_d[NW-1:0]);
      end
      W_D1: begin
        tin_d = '0;
        din_d = to_phy(wdat_d[BW-1:NW]);
      end
      default: ;
    endcase
    dci_d      = !(state_d inside {R_WAIT, R_CAP0, R_CAP1});
    wr_ready_d = (state_d == IDLE) || (state_d == W_POST);
    rd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_div) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wdat_q     <= '0;
      rd_data_q  <= '0;
      cap_lo_q   <= '0;
      cnt_q      <= '0;
      din_q      <= '0;
      tin_q      <= '1;
      dci_q      <= 1'b1;
      rd_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      wr_ready_q <= 1'b1;
      rd_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wdat_q     <= wdat_d;
      rd_data_q  <= rd_data_d;
      cap_lo_q   <= cap_lo_d;
      cnt_q      <= cnt_d;
      din_q      <= din_d;
      tin_q      <= tin_d;
      dci_q      <= dci_d;
      rd_valid_q <= rd_valid_d;
      cmd_err_q  <= cmd_err_d;
      wr_ready_q <= wr_ready_d;
      rd_ready_q <= rd_ready_d;
    end
  end

  assign din         = din_q;
  assign tin         = tin_q;
  assign dci_disable = dci_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign cmd_err     = cmd_err_q;
  assign wr_ready    = wr_ready_q;
  assign rd_ready    = rd_ready_q;

endmodule

// File: tb/tb_dq_lane_burst.sv
// Directed-plus-random bench for dq_lane_burst; expected PHY words and read bursts
// are built from the lane bit-ordering rules and the cycle offsets of each command.
module tb_dq_lane_burst;
  localparam int W = 8;

  logic        clk_div = 1'b0;
  logic        rst_n;
  logic        wr_start;
  logic [63:0] wr_data;
  logic        wr_ready;
  logic        rd_start;
  logic [4:0]  rd_lat;
  logic        rd_ready;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic [31:0] din;
  logic [31:0] tin;
  logic [31:0] dout;
  logic        dci_disable;
  logic        cmd_err;

  int total = 0;
  int bad   = 0;
  logic [63:0] last_rd = '0;

  dq_lane_burst #(.DQ_WIDTH(W), .LAT_BITS(5)) dut (
    .clk_div(clk_div), .rst_n(rst_n),
    .wr_start(wr_start), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_lat(rd_lat), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .din(din), .tin(tin), .dout(dout),
    .dci_disable(dci_disable), .cmd_err(cmd_err)
  );

  always #5 clk_div = ~clk_div;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_div);
    #1;
  endtask

  // din word for beat group g (0: beats 0-3, 1: beats 4-7): din[4i+k] = bit i of beat 4g+k.
  function automatic logic [31:0] exp_din(input logic [63:0] d, input int g);
    logic [31:0] r;
    logic [7:0]  beat;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      beat = d[(4*g+k)*8 +: 8];
      for (int i = 0; i < W; i++) r[4*i+k] = beat[i];
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      for (int k = 0; k < 4; k++) begin
        r[k*8+i]     = w0[4*i+k];
        r[(4+k)*8+i] = w1[4*i+k];
      end
    return r;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tin"}, 64'(tin), 64'hFFFF_FFFF);
    chk({tag, "_din"}, 64'(din), 64'h0);
    chk({tag, "_dci"}, 64'(dci_disable), 64'h1);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'h0);
    chk({tag, "_cmd_err"}, 64'(cmd_err), 64'h0);
    chk({tag, "_wr_ready"}, 64'(wr_ready), 64'h1);
    chk({tag, "_rd_ready"}, 64'(rd_ready), 64'h1);
    chk({tag, "_rd_data"}, rd_data, 64'h0);
  endtask

  // Write from IDLE; optional read collision at start, optional second burst and/or
  // read request driven during the post-amble cycle.
  task automatic wr_burst(input logic [63:0] d0, input bit seam, input logic [63:0] d1,
                          input bit rd_at_start, input bit rd_at_post);
    wr_start = 1'b1; wr_data = d0; rd_start = rd_at_start; rd_lat = 5'(1);
    tick();
    wr_start = 1'b0; rd_start = 1'b0; wr_data = 64'($urandom);
    chk("wr_pre_tin", 64'(tin), 64'h0);
    chk("wr_pre_din", 64'(din), 64'h0);
    chk("wr_pre_err", 64'(cmd_err), 64'(rd_at_start));
    chk("wr_pre_ready", {62'h0, wr_ready, rd_ready}, 64'h0);
    tick();
    chk("wr_d0_din", 64'(din), 64'(exp_din(d0, 0)));
    chk("wr_d0_tin", 64'(tin), 64'h0);
    chk("wr_d0_err", 64'(cmd_err), 64'h0);
    tick();
    chk("wr_d1_din", 64'(din), 64'(exp_din(d0, 1)));
    chk("wr_d1_tin", 64'(tin), 64'h0);
    chk("wr_d1_dci", 64'(dci_disable), 64'h1);
    tick();
    chk("wr_post_din", 64'(din), 64'h0);
    chk("wr_post_tin", 64'(tin), 64'h0);
    chk("wr_post_ready", {62'h0, wr_ready, rd_ready}, 64'h2);
    wr_start = seam; wr_data = d1; rd_start = rd_at_post;
    tick();
    wr_start = 1'b0; rd_start = 1'b0;
    chk("wr_n4_err", 64'(cmd_err), 64'(rd_at_post));
    chk("wr_n4_dci", 64'(dci_disable), 64'h1);
    if (seam) begin
      chk("seam_d0_din", 64'(din), 64'(exp_din(d1, 0)));
      chk("seam_d0_tin", 64'(tin), 64'h0);
      tick();
      chk("seam_d1_din", 64'(din), 64'(exp_din(d1, 1)));
      chk("seam_d1_tin", 64'(tin), 64'h0);
      tick();
      chk("seam_post_tin", 64'(tin), 64'h0);
      chk("seam_post_din", 64'(din), 64'h0);
      tick();
    end
    chk("wr_idle_tin", 64'(tin), 64'hFFFF_FFFF);
    chk("wr_idle_din", 64'(din), 64'h0);
    chk("wr_idle_ready", {62'h0, wr_ready, rd_ready}, 64'h3);
    tick();
    chk("wr_idle2_dci", 64'(dci_disable), 64'h1);
    chk("wr_idle2_valid", 64'(rd_valid), 64'h0);
    chk("wr_idle2_err", 64'(cmd_err), 64'h0);
  endtask

  // Read with latency lat; dout carries noise outside the two capture cycles.
  task automatic rd_burst(input int lat, input logic [31:0] w0, input logic [31:0] w1,
                          input bit wr_drop);
    logic [63:0] exp;
    exp = exp_rd(w0, w1);
    rd_start = 1'b1; rd_lat = 5'(lat); dout = $urandom;
    tick();
    rd_start = 1'b0; rd_lat = 5'($urandom);
    chk("rd_acc_dci", 64'(dci_disable), 64'h0);
    chk("rd_acc_ready", {62'h0, wr_ready, rd_ready}, 64'h0);
    chk("rd_acc_valid", 64'(rd_valid), 64'h0);
    for (int j = 1; j <= lat + 3; j++) begin
      wr_start = wr_drop && (j == 1);
      dout = (j == lat + 2) ? w0 : (j == lat + 3) ? w1 : $urandom;
      tick();
      wr_start = 1'b0;
      chk("rd_tin", 64'(tin), 64'hFFFF_FFFF);
      chk("rd_err", 64'(cmd_err), 64'(wr_drop && (j == 1)));
      if (j <= lat + 2) begin
        chk("rd_wait_dci", 64'(dci_disable), 64'h0);
        chk("rd_wait_valid", 64'(rd_valid), 64'h0);
      end else begin
        chk("rd_done_valid", 64'(rd_valid), 64'h1);
        chk("rd_done_data", rd_data, exp);
        chk("rd_done_dci", 64'(dci_disable), 64'h1);
        chk("rd_done_ready", 64'(rd_ready), 64'h1);
      end
    end
    dout = $urandom;
    last_rd = exp;
  endtask

  initial begin
    rst_n = 1'b0; wr_start = 1'b0; rd_start = 1'b0;
    wr_data = '0; rd_lat = '0; dout = '0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();
    chk_reset_vals("idle_after_reset");

    wr_burst(64'h8877_6655_4433_2211, 1'b0, 64'h0, 1'b0, 1'b0);
    wr_burst({$urandom, $urandom}, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);

    rd_burst(3, 32'hFFFF_FFFF, 32'h0000_000F, 1'b0);
    chk("rd_lat3_literal", rd_data, 64'h0101_0101_FFFF_FFFF);
    tick();
    chk("rd_valid_pulse", 64'(rd_valid), 64'h0);
    chk("rd_data_hold", rd_data, 64'h0101_0101_FFFF_FFFF);

    wr_burst({$urandom, $urandom}, 1'b0, 64'h0, 1'b1, 1'b0);
    wr_burst({$urandom, $urandom}, 1'b0, 64'h0, 1'b0, 1'b1);
    wr_burst({$urandom, $urandom}, 1'b1, {$urandom, $urandom}, 1'b0, 1'b1);
    chk("no_read_after_drop", rd_data, 64'h0101_0101_FFFF_FFFF);

    rd_burst(0, $urandom, $urandom, 1'b1);
    rd_burst(31, $urandom, $urandom, 1'b0);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 0)
        wr_burst({$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        rd_burst(int'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    rd_burst(int'($urandom_range(0, 4)), $urandom, $urandom, 1'b0);
    rd_burst(int'($urandom_range(0, 4)), $urandom, $urandom, 1'b0);
    tick();
    chk("b2b_valid_low", 64'(rd_valid), 64'h0);
    chk("b2b_hold", rd_data, last_rd);

    wr_start = 1'b1; wr_data = {$urandom, $urandom};
    tick();
    wr_start = 1'b0;
    tick();
    chk("mid_wr_in_d0", 64'(tin), 64'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals("mid_wr_reset");
    tick();
    chk("mid_wr_stays_idle", 64'(tin), 64'hFFFF_FFFF);

    rd_start = 1'b1; rd_lat = 5'd10;
    tick();
    rd_start = 1'b0;
    tick();
    chk("mid_rd_in_wait", 64'(dci_disable), 64'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_vals("mid_rd_reset");
    for (int j = 0; j < 14; j++) begin
      dout = $urandom;
      tick();
      chk("mid_rd_no_valid", 64'(rd_valid), 64'h0);
      chk("mid_rd_dci", 64'(dci_disable), 64'h1);
    end
    chk("mid_rd_data_zero", rd_data, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
